// File: rtl/data_bus_responder_pkg.sv
// Shared types, funct3 codes and access-legality helpers for the data-bus responder.
package data_bus_responder_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_t;
    typedef logic [3:0] byte_en_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic logic func3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // f3[1:0] is the size code for both loads and stores: 01 = half, 10 = word.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
        return ((f3[1:0] == 2'b01) && lane[0]) || ((f3[1:0] == 2'b10) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/bus_lane_align.sv
// Combinational lane steering: store data/byte enables and load extraction with extension.
module bus_lane_align
    import data_bus_responder_pkg::*;
(
    input  logic [2:0]  st_func3,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_wdata,
    output byte_en_t    st_be,
    output logic [31:0] st_word,
    input  logic [2:0]  ld_func3,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Replicating the data into every lane lets the byte enables alone pick the target.
    always_comb begin
        st_be   = '0;
        st_word = '0;
        case (st_func3)
            F3_SB: begin
                st_be   = 4'b0001 << st_lane;
                st_word = {4{st_wdata[7:0]}};
            end
            F3_SH: begin
                st_be   = st_lane[1] ? 4'b1100 : 4'b0011;
                st_word = {2{st_wdata[15:0]}};
            end
            F3_SW: begin
                st_be   = 4'b1111;
                st_word = st_wdata;
            end
            default: ;
        endcase
    end

    assign ld_byte = ld_raw[{ld_lane, 3'b000} +: 8];
    assign ld_half = ld_lane[1] ? ld_raw[31:16] : ld_raw[15:0];

    always_comb begin
        ld_data = '0;
        case (ld_func3)
            F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_data = {24'b0, ld_byte};
            F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            F3_LHU:  ld_data = {16'b0, ld_half};
            F3_LW:   ld_data = ld_raw;
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/data_bus_responder.sv
// Target-side data-bus responder: word RAM with wait states, lane handling and error replies.
module data_bus_responder
    import data_bus_responder_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [31:0] bus_addr,
    input  logic [2:0]  bus_func3,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic        bus_err,
    output state_t      dbg_state
);

    // Handshake: the initiator holds bus_req and the request fields until a one-cycle
    // bus_ready; fields are captured in IDLE, and bus_err/bus_rdata qualify that pulse.

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);
    localparam logic [3:0]  WS   = 4'(WAIT_STATES);

    state_t      state;
    logic [3:0]  cnt;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [2:0]  cap_func3;
    logic [31:0] cap_wdata;

    logic [31:0] ram [DEPTH];
    logic [31:0] rd_word;

    logic          act_we;
    logic [31:0]   act_addr;
    logic [2:0]    act_func3;
    logic [31:0]   act_wdata;
    logic [31:0]   act_off;
    logic [AW-1:0] act_idx;
    logic          access_ok;
    logic          enter_resp;
    byte_en_t      st_be;
    logic [31:0]   st_word;
    logic [31:0]   ld_data;

    // With zero wait states RESP is entered on the accept edge, so the RAM port
    // must see the live request rather than the not-yet-captured copy.
    assign act_we    = (state == IDLE) ? bus_we    : cap_we;
    assign act_addr  = (state == IDLE) ? bus_addr  : cap_addr;
    assign act_func3 = (state == IDLE) ? bus_func3 : cap_func3;
    assign act_wdata = (state == IDLE) ? bus_wdata : cap_wdata;

    assign act_off   = act_addr - BASE_ADDR;
    assign act_idx   = act_off[AW+1:2];
    assign access_ok = func3_legal(act_we, act_func3) && (act_off < SPAN) &&
                       !misaligned(act_func3, act_addr[1:0]);

    assign enter_resp = !reset &&
        (((state == IDLE) && bus_req && access_ok && (WS == 4'd0)) ||
         ((state == WAIT) && (cnt == WS)));

    bus_lane_align u_align (
        .st_func3 (act_func3),
        .st_lane  (act_addr[1:0]),
        .st_wdata (act_wdata),
        .st_be    (st_be),
        .st_word  (st_word),
        .ld_func3 (cap_func3),
        .ld_lane  (cap_addr[1:0]),
        .ld_raw   (rd_word),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (enter_resp) begin
            rd_word <= ram[act_idx];
            if (act_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (st_be[b])
                        ram[act_idx][8*b +: 8] <= st_word[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bus_ready <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            bus_ready <= 1'b0;
            bus_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus_req) begin
                        cap_we    <= bus_we;
                        cap_addr  <= bus_addr;
                        cap_func3 <= bus_func3;
                        cap_wdata <= bus_wdata;
                        if (!access_ok) begin
                            state     <= ERR;
                            bus_ready <= 1'b1;
                            bus_err   <= 1'b1;
                        end else if (WS == 4'd0) begin
                            state     <= RESP;
                            bus_ready <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'd1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == WS) begin
                        state     <= RESP;
                        bus_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP, ERR: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus_rdata = ((state == RESP) && !cap_we) ? ld_data : '0;
    assign dbg_state = state;

endmodule

// File: tb/tb_data_bus_responder.sv
// Randomised scoreboard bench for data_bus_responder: one instance with one wait state, one with none.
module tb_data_bus_responder;
  import data_bus_responder_pkg::*;

  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam int          NBYTES = 1024;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] acc;
    logic [31:0] lat;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [2:0]  f3    [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err   [2];
  state_t      st    [2];

  data_bus_responder #(.DEPTH(256), .BASE_ADDR(BASE), .WAIT_STATES(1)) dut0 (
    .clk(clk), .reset(reset), .bus_req(req[0]), .bus_we(we[0]), .bus_addr(addr[0]),
    .bus_func3(f3[0]), .bus_wdata(wdata[0]), .bus_rdata(rdata[0]), .bus_ready(ready[0]),
    .bus_err(err[0]), .dbg_state(st[0])
  );

  data_bus_responder #(.DEPTH(256), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut1 (
    .clk(clk), .reset(reset), .bus_req(req[1]), .bus_we(we[1]), .bus_addr(addr[1]),
    .bus_func3(f3[1]), .bus_wdata(wdata[1]), .bus_rdata(rdata[1]), .bus_ready(ready[1]),
    .bus_err(err[1]), .dbg_state(st[1])
  );

  // scoreboard state
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int checks = 0;
  int errors = 0;
  logic [7:0] mem [2][NBYTES];
  bit just_done [2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Byte-addressed reference: legality from the ISA size/sign rules, data from a byte array.
  function automatic void model(input int d, input bit w, input logic [31:0] a,
                                input logic [2:0] f, input logic [31:0] wd,
                                output bit e, output logic [31:0] r);
    int size;
    bit legal;
    logic [31:0] off;
    logic [31:0] val;
    size = 1 << f[1:0];
    if (w) legal = (f <= 3'd2);
    else   legal = (f <= 3'd2) || (f == 3'd4) || (f == 3'd5);
    off = a - BASE;
    e = !legal || (off >= 32'(NBYTES)) || ((a % 32'(size)) != 0);
    r = '0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < size; i++) mem[d][off + 32'(i)] = wd[8*i +: 8];
      end else begin
        val = '0;
        for (int i = 0; i < size; i++) val = val | (32'(mem[d][off + 32'(i)]) << (8*i));
        if (size < 4 && !f[2] && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
        r = val;
      end
    end
  endfunction

  // driver: called at a negedge; returns at the negedge where bus_ready is seen
  task automatic xfer(input int d, input bit w, input logic [31:0] a,
                      input logic [2:0] f, input logic [31:0] wd);
    exp_t e;
    bit me;
    logic [31:0] mr;
    int n;
    we[d] = w; addr[d] = a; f3[d] = f; wdata[d] = wd; req[d] = 1'b1;
    model(d, w, a, f, wd, me, mr);
    e.err = me;
    e.rdata = mr;
    e.acc = cyc + (just_done[d] ? 32'd1 : 32'd0);
    e.lat = me ? 32'd1 : ((d == 0) ? 32'd2 : 32'd1);
    if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready[d] && n < 40);
    if (!ready[d]) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout dut%0d: got no ready in %0d cycles required one", d, n);
      req[d] = 1'b0;
      just_done[d] = 1'b0;
    end else begin
      just_done[d] = 1'b1;
    end
  endtask

  task automatic idle(input int d, input int n);
    req[d] = 1'b0;
    repeat (n) @(negedge clk);
    just_done[d] = 1'b0;
  endtask

  // monitors
  exp_t m0;
  exp_t m1;
  always @(negedge clk) begin
    if (!reset) begin
      if (ready[0]) begin
        if (exp_q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready0: got ready=1 required no pending transfer");
        end else begin
          m0 = exp_q0.pop_front();
          chk("err0", 32'(err[0]), 32'(m0.err));
          chk("rdata0", rdata[0], m0.rdata);
          chk("latency0", cyc - m0.acc, m0.lat);
        end
      end else begin
        chk("idle_rdata0", rdata[0], 32'd0);
        chk("idle_err0", 32'(err[0]), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (ready[1]) begin
        if (exp_q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready1: got ready=1 required no pending transfer");
        end else begin
          m1 = exp_q1.pop_front();
          chk("err1", 32'(err[1]), 32'(m1.err));
          chk("rdata1", rdata[1], m1.rdata);
          chk("latency1", cyc - m1.acc, m1.lat);
        end
      end else begin
        chk("idle_rdata1", rdata[1], 32'd0);
        chk("idle_err1", 32'(err[1]), 32'd0);
      end
    end
  end

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: got no end of test required finish before time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  f;
    bit          w;
    int          r;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; f3[d] = '0; wdata[d] = '0;
      just_done[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", 32'(ready[d]), 32'd0);
      chk("reset_err", 32'(err[d]), 32'd0);
      chk("reset_rdata", rdata[d], 32'd0);
      chk("reset_state", 32'(st[d]), 32'(IDLE));
    end
    reset = 1'b0;
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) xfer(d, 1'b1, BASE + 32'(4*i), F3_SW, $urandom());
      idle(d, 1);
    end

    // directed sequence on the one-wait-state instance
    xfer(0, 1'b1, BASE + 32'h10, F3_SW,  32'hDEAD_BEEF);
    xfer(0, 1'b0, BASE + 32'h10, F3_LW,  32'h0);
    xfer(0, 1'b0, BASE + 32'h13, F3_LB,  32'h0);
    xfer(0, 1'b0, BASE + 32'h13, F3_LBU, 32'h0);
    xfer(0, 1'b0, BASE + 32'h10, F3_LH,  32'h0);
    xfer(0, 1'b0, BASE + 32'h12, F3_LHU, 32'h0);
    xfer(0, 1'b1, BASE + 32'h11, F3_SB,  32'h0000_0012);
    xfer(0, 1'b0, BASE + 32'h10, F3_LW,  32'h0);
    xfer(0, 1'b1, BASE + 32'h12, F3_SH,  32'h0000_5566);
    xfer(0, 1'b0, BASE + 32'h10, F3_LW,  32'h0);
    xfer(0, 1'b0, BASE + 32'h11, F3_LW,  32'h0);
    xfer(0, 1'b1, 32'h0FFF_FFFC, F3_SW,  32'hCAFE_F00D);
    xfer(0, 1'b0, BASE + 32'(NBYTES), F3_LW, 32'h0);
    xfer(0, 1'b0, BASE + 32'h10, 3'b011, 32'h0);
    xfer(0, 1'b1, BASE + 32'h10, 3'b100, 32'h1234_5678);
    xfer(0, 1'b0, BASE + 32'h10, F3_LW,  32'h0);
    idle(0, 2);

    // reset while the store sits in WAIT: the edge that would enter RESP is the reset edge
    we[0] = 1'b1; addr[0] = BASE; f3[0] = F3_SW; wdata[0] = 32'h1122_3344; req[0] = 1'b1;
    @(negedge clk);
    chk("wait_state", 32'(st[0]), 32'(WAIT));
    reset = 1'b1;
    req[0] = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(ready[0]), 32'd0);
    chk("abort_state", 32'(st[0]), 32'(IDLE));
    reset = 1'b0;
    @(negedge clk);
    xfer(0, 1'b0, BASE, F3_LW, 32'h0);
    idle(0, 2);

    // zero-wait-state instance with bus_req held high across store/load pairs
    for (int k = 0; k < 4; k++) begin
      a = BASE + 32'(4 * $urandom_range(0, 255));
      xfer(1, 1'b1, a, F3_SW, $urandom());
      xfer(1, 1'b0, a, F3_LW, 32'h0);
    end
    idle(1, 2);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 300; i++) begin
        w = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 9);
        if (r == 0)      f = 3'($urandom_range(0, 7));
        else if (w)      f = 3'($urandom_range(0, 2));
        else if (r < 4)  f = 3'($urandom_range(4, 5));
        else             f = 3'($urandom_range(0, 2));
        r = $urandom_range(0, 9);
        if (r == 0)      a = $urandom();
        else if (r == 1) a = BASE - 32'd4 + 32'($urandom_range(0, 7));
        else if (r == 2) a = BASE + 32'(NBYTES - 4) + 32'($urandom_range(0, 7));
        else             a = BASE + 32'($urandom_range(0, NBYTES - 1));
        xfer(d, w, a, f, $urandom());
        if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(1, 3));
      end
      idle(d, 2);
    end

    repeat (4) @(negedge clk);
    chk("queue0_drained", 32'(exp_q0.size()), 32'd0);
    chk("queue1_drained", 32'(exp_q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Bus responder (target side) for the core's data-bus initiator: serves loads and stores issued by the RV32I datapath against an internal word-organised data RAM.
- Adds a req/ready handshake with a configurable wait-state count, byte/half/word lane handling with sign/zero extension, and an error response for misaligned, out-of-range or illegal-size accesses.
- Sits between the core's data port and the top-level interconnect; one instance per data RAM region.

Parameters:
- DEPTH, 256, number of 32-bit words in the RAM; must be a power of two.
- BASE_ADDR, 32'h1000_0000, byte address of word 0; must be aligned to DEPTH*4.
- WAIT_STATES, 1, extra cycles between accept and response; legal range 0..15.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- bus_req  in  1  initiator requests a transfer; held high until bus_ready.
- bus_we  in  1  1 = store, 0 = load; sampled at accept.
- bus_addr  in  32  byte address; sampled at accept.
- bus_func3  in  3  RV32I funct3 access size/sign code; sampled at accept.
- bus_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]); sampled at accept.
- bus_rdata  out  32  load result, extended; valid only while bus_ready=1 and bus_we=0 captured, else 0.
- bus_ready  out  1  one-cycle pulse that completes the transfer.
- bus_err  out  1  qualifies bus_ready: 1 = access rejected.

Behaviour:
- Reset (sync, highest priority): state IDLE, wait counter 0, bus_ready 0, bus_err 0, bus_rdata 0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP, ERR.
- IDLE: on bus_req=1, capture we/addr/func3/wdata (accept edge), then check the access:
  - Illegal func3 (loads 011/110/111; stores 1xx/011) -> ERR.
  - Out of range (bus_addr - BASE_ADDR >= DEPTH*4, unsigned) -> ERR.
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> ERR.
  - Otherwise -> WAIT if WAIT_STATES>0, else RESP.
- WAIT: counter counts up from 1 and leaves for RESP when it equals WAIT_STATES. Total accept-to-ready latency is WAIT_STATES+1 cycles.
- RESP: bus_ready=1, bus_err=0 for exactly one cycle.
  - Store: the RAM write is performed on the clock edge entering RESP, so a load in the next transaction sees it.
  - Load: bus_rdata driven from the registered RAM read.
  - Always returns to IDLE.
- ERR: bus_ready=1, bus_err=1, bus_rdata=0 for one cycle; no RAM write; then IDLE. ERR latency is always 1 cycle regardless of WAIT_STATES.
- Changes on the bus_* inputs after accept are ignored. bus_req still high in the cycle after bus_ready is treated as a new transaction, so back-to-back transfers are allowed.
- Word index is addr_off[log2(DEPTH)+1:2] with addr_off = addr - BASE_ADDR; the lane is addr[1:0].
- Store lanes:
  - SB (000) writes wdata[7:0] to byte lane addr[1:0].
  - SH (001) writes wdata[15:0] to lanes {addr[1],0}+1 and {addr[1],0}.
  - SW (010) writes all four lanes.
  - Implemented as byte enables; unwritten bytes keep their value.
- Load extension:
  - LB (000) sign-extends the selected byte; LBU (100) zero-extends it.
  - LH (001) sign-extends the selected half; LHU (101) zero-extends it.
  - LW (010) passes the word through unchanged.
- Reset asserted in any state aborts the transfer with no bus_ready pulse. If reset coincides with the edge entering RESP, the write is suppressed.

Decomposition:
- Shared defines file gains load/store funct3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
- Shared package gains the FSM state enum (IDLE, WAIT, RESP, ERR) and a 4-bit byte-enable type.
- One combinational sub-module, bus_lane_align:
  - Store side: (func3, addr[1:0], wdata) -> byte enables + lane-shifted write word.
  - Load side: (func3, addr[1:0], raw word) -> extended rdata.

Test Plan:
- WAIT_STATES=1, SW 0xDEADBEEF @0x1000_0010 then LW @0x1000_0010 -> each ready exactly 2 cycles after accept, err=0, rdata=0xDEADBEEF.
- After the above: LB @0x1000_0013 -> 0xFFFFFFDE; LBU @0x1000_0013 -> 0x000000DE; LH @0x1000_0010 -> 0xFFFFBEEF; LHU @0x1000_0012 -> 0x0000DEAD.
- SB 0x12 @0x1000_0011 onto 0xDEADBEEF, then LW -> 0xDEAD12EF; SH 0x5566 @0x1000_0012 -> LW 0x556612EF.
- LW @0x1000_0011 (misaligned), SW @0x0FFF_FFFC and LW @BASE+DEPTH*4 (out of range), load func3=011 (illegal) -> each: ready+err pulse 1 cycle after accept, rdata=0, RAM unchanged.
- WAIT_STATES=0 with bus_req held high over 4 back-to-back SW/LW pairs -> ready every 2nd cycle, each LW returns the preceding SW data.
- Reset asserted during WAIT of an SW 0x11223344 @BASE -> no ready pulse, state IDLE next cycle, later LW @BASE returns the old word.
